// File: rtl/hamming_column_stream_decoder.sv
// Column-serial Hamming(7,4) decoder: corrects one bit per 7-bit column, de-interleaves
// NUM_COLS columns into a DATA_W word. Optional ERR_STATS_EN adds a lifetime err_total count.

module hamming74_col_fix (
    input  logic [6:0] col_data,
    output logic [3:0] nib,
    output logic       syn_nz
);
    logic [2:0] syn;
    logic [6:0] fixed;

    always_comb begin
        syn[2] = col_data[3] ^ col_data[4] ^ col_data[5] ^ col_data[6];
        syn[1] = col_data[1] ^ col_data[2] ^ col_data[5] ^ col_data[6];
        syn[0] = col_data[0] ^ col_data[2] ^ col_data[4] ^ col_data[6];
        fixed  = col_data;
        // Syndrome is the 1-based Hamming position of the bad bit.
        if (syn != 3'd0)
            fixed[syn - 3'd1] = ~col_data[syn - 3'd1];
        nib    = {fixed[6], fixed[5], fixed[4], fixed[2]};
        syn_nz = |syn;
    end
endmodule

module hamming_column_stream_decoder #(
    parameter int NUM_COLS = 15,
    parameter int DATA_W   = 44
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              col_valid,
    output logic              col_ready,
    input  logic [6:0]        col_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        corr_count,
    output logic              pad_err
`ifdef ERR_STATS_EN
    ,
    output logic [15:0]       err_total
`endif
);
    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    generate
        if (DATA_W > 4 * NUM_COLS) begin : g_param_chk
            $error("DATA_W must not exceed 4*NUM_COLS");
        end
    endgenerate

    typedef enum logic {COLLECT, DONE} state_t;

    state_t                     state, state_nxt;
    logic [IDX_W-1:0]           col_idx;
    logic [NUM_COLS-1:0][3:0]   slots, slots_nxt;
    logic [NUM_COLS-1:0][3:0]   pad_mask;
    logic [DATA_W-1:0]          data_nxt;
    logic [3:0]                 nib;
    logic                       syn_nz;
    logic                       accept, last_col, out_hs;

    hamming74_col_fix u_fix (
        .col_data (col_data),
        .nib      (nib),
        .syn_nz   (syn_nz)
    );

    assign col_ready = (state == COLLECT);
    assign out_valid = (state == DONE);
    assign accept    = col_valid & col_ready;
    assign out_hs    = out_valid & out_ready;
    assign last_col  = (col_idx == IDX_W'(NUM_COLS - 1));

    // Slot (c,r) carries data bit r*NUM_COLS+c; anything past DATA_W is padding.
    generate
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                assign pad_mask[c][r] = ((r * NUM_COLS + c) >= DATA_W) ? 1'b1 : 1'b0;
            end
        end
        for (genvar k = 0; k < DATA_W; k++) begin : g_deint
            assign data_nxt[k] = slots_nxt[k % NUM_COLS][k / NUM_COLS];
        end
    endgenerate

    // Include the column being accepted so the last beat lands in data_out on the same edge.
    always_comb begin
        slots_nxt = slots;
        if (accept)
            slots_nxt[col_idx] = nib;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && last_col) state_nxt = DONE;
            DONE:    if (out_ready)          state_nxt = COLLECT;
            default:                         state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            col_idx    <= '0;
            slots      <= '0;
            data_out   <= '0;
            corr_count <= '0;
            pad_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                slots   <= slots_nxt;
                col_idx <= last_col ? '0 : col_idx + IDX_W'(1);
                if (syn_nz && corr_count != 4'hF)
                    corr_count <= corr_count + 4'd1;
                if (|(nib & pad_mask[col_idx]))
                    pad_err <= 1'b1;
                if (last_col)
                    data_out <= data_nxt;
            end
            if (out_hs) begin
                col_idx    <= '0;
                corr_count <= '0;
                pad_err    <= 1'b0;
            end
        end
    end

`ifdef ERR_STATS_EN
    logic [16:0] err_sum;
    assign err_sum = {1'b0, err_total} + {13'd0, corr_count};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_total <= '0;
        else if (out_hs)
            err_total <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_hamming_column_stream_decoder.sv
// Table-driven bench with a scoreboard queue; optional ERR_STATS_EN checks err_total.

module tb_hamming_column_stream_decoder;
    localparam int NC = 15;
    localparam int DW = 44;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          col_valid = 1'b0;
    logic          col_ready;
    logic [6:0]    col_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] data_out;
    logic [3:0]    corr_count;
    logic          pad_err;
`ifdef ERR_STATS_EN
    logic [15:0]   err_total;
`endif

    hamming_column_stream_decoder #(.NUM_COLS(NC), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .col_data   (col_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .corr_count (corr_count),
        .pad_err    (pad_err)
`ifdef ERR_STATS_EN
        ,
        .err_total  (err_total)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            fc0;
        logic [6:0]    m0;
        int            fc1;
        logic [6:0]    m1;
        logic [DW-1:0] exp_data;
        logic [3:0]    exp_corr;
        logic          exp_pad;
    } vec_t;

    vec_t vt[7];
    vec_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   model_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] enc_col(input logic [DW-1:0] d, input int c);
        logic [3:0] n;
        for (int r = 0; r < 4; r++) begin
            int k;
            k = r * NC + c;
            n[r] = (k < DW) ? d[k] : 1'b0;
        end
        return {n[3], n[2], n[1], n[1] ^ n[2] ^ n[3], n[0],
                n[0] ^ n[2] ^ n[3], n[0] ^ n[1] ^ n[3]};
    endfunction

    // Drive ncols beats; when the full word is sent, check the 1-cycle out_valid latency.
    task automatic stream(input vec_t v, input int ncols, input bit gaps);
        for (int c = 0; c < ncols; c++) begin
            logic [6:0] col;
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            col = enc_col(v.data, c);
            if (c == v.fc0) col = col ^ v.m0;
            if (c == v.fc1) col = col ^ v.m1;
            if (c == NC - 1) chk("out_valid_before_last", {63'd0, out_valid}, 64'd0);
            col_valid = 1'b1;
            col_data  = col;
            @(posedge clk);
            #1;
            col_valid = 1'b0;
        end
        if (ncols == NC) chk("out_valid_latency", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        chk("drain_timeout_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit gaps);
        sb.push_back(v);
        stream(v, NC, gaps);
        drain();
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_col_ready"},  {63'd0, col_ready}, 64'd1);
        chk({tag, "_out_valid"},  {63'd0, out_valid}, 64'd0);
        chk({tag, "_data_out"},   64'(data_out), 64'd0);
        chk({tag, "_corr_count"}, 64'(corr_count), 64'd0);
        chk({tag, "_pad_err"},    {63'd0, pad_err}, 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        check_reset_state(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_total = 0;
    endtask

    // Scoreboard: compare on the handshake cycle, at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 64'd1, 64'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("data_out",   64'(data_out), 64'(e.exp_data));
                chk("corr_count", 64'(corr_count), 64'(e.exp_corr));
                chk("pad_err",    {63'd0, pad_err}, {63'd0, e.exp_pad});
                model_total += int'(e.exp_corr);
            end
        end
    end

    initial begin
        vec_t bp;
        vt[0] = '{44'h123456789AB, -1, 7'h00, -1, 7'h00, 44'h123456789AB, 4'd0, 1'b0};
        vt[1] = '{44'h123456789AB,  0, 7'h01, -1, 7'h00, 44'h123456789AB, 4'd1, 1'b0};
        vt[2] = '{44'hAAAAAAAAAAA,  5, 7'h60, -1, 7'h00, 44'hAA2AAAAAAAA, 4'd1, 1'b1};
        vt[3] = '{44'h0F0F0F0F0F0, -1, 7'h00, -1, 7'h00, 44'h0F0F0F0F0F0, 4'd0, 1'b0};
        vt[4] = '{44'h123456789AB,  3, 7'h40, 14, 7'h08, 44'h123456789AB, 4'd2, 1'b0};
        vt[5] = '{44'hFFFFFFFFFFF,  9, 7'h10, 12, 7'h02, 44'hFFFFFFFFFFF, 4'd2, 1'b0};
        vt[6] = '{44'h00000000000,  7, 7'h01, -1, 7'h00, 44'h00000000000, 4'd1, 1'b0};

        #2;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_vec(vt[i], i >= 4);

        // Backpressure: word held in DONE, stray beats must not be consumed.
        bp = vt[4];
        out_ready = 1'b0;
        sb.push_back(bp);
        stream(bp, NC, 1'b0);
        col_valid = 1'b1;
        col_data  = 7'h7F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_col_ready", {63'd0, col_ready}, 64'd0);
            chk("bp_data_out",  64'(data_out), 64'(bp.exp_data));
        end
        col_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        run_vec(vt[0], 1'b0);

        // Reset mid-word discards the partial word.
        stream(vt[2], 7, 1'b0);
        chk("midword_corr_count", 64'(corr_count), 64'd1);
`ifdef ERR_STATS_EN
        chk("err_total_running", 64'(err_total), 64'(model_total));
`endif
        pulse_reset("midword_reset");
        run_vec(vt[3], 1'b0);

`ifdef ERR_STATS_EN
        pulse_reset("stats_reset");
        chk("err_total_cleared", 64'(err_total), 64'd0);
        run_vec(vt[1], 1'b0);
        run_vec(vt[4], 1'b1);
        run_vec(vt[0], 1'b0);
        chk("err_total_three_words", 64'(err_total), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
